// File: rtl/mpu_burst_reader_if.sv
// ---------------------------------------------------------------------------
// mpu_burst_reader_if
//   Command/response link between mpu_burst_reader and a byte-level I2C
//   master.
//   cmd_valid/cmd_ready : command handshake (transfer when both high)
//   cmd_op              : 0=START+write, 1=write, 2=read+ACK, 3=read+NACK+STOP
//   cmd_data            : byte to write (ops 0/1), 0 for reads
//   rsp_valid           : one-cycle pulse, command complete
//   rsp_data            : byte read (ops 2/3)
//   rsp_nack            : slave NACKed a write (ops 0/1)
//   Modports: master = reader side (issues commands), slave = I2C master side.
// ---------------------------------------------------------------------------
interface mpu_burst_reader_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack
  );
endinterface

// File: rtl/mpu_burst_reader.sv
// ---------------------------------------------------------------------------
// mpu_burst_reader
//   Periodically reads the 14 data registers of an MPU6050 (accel XYZ, temp,
//   gyro XYZ) through a byte-level I2C master: writes the register pointer,
//   then burst-reads 14 bytes and publishes them atomically with a one-cycle
//   data_valid pulse.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   enable                   : run periodic bursts (0 = finish current, idle)
//   bus (master modport)     : command/response link to the I2C master
//   mpu_data_packed_0..13    : published bytes, index = offset from START_REG
//   data_valid               : one-cycle pulse when a new set is published
//   busy                     : high from burst start until DONE/ERR exit
//   err_cnt                  : saturating count of aborted bursts
// Configuration:
//   `define MPU_READER_TIMEOUT_EN enables a per-command watchdog of
//   TIMEOUT_CYCLES clocks; without it the FSM waits indefinitely.
// ---------------------------------------------------------------------------
module mpu_burst_reader #(
  parameter int         SAMPLE_DIV     = 100000,
  parameter logic [6:0] DEV_ADDR       = 7'h68,
  parameter logic [7:0] START_REG      = 8'h3B,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  mpu_burst_reader_if.master   bus,
  output logic [7:0]           mpu_data_packed_0,
  output logic [7:0]           mpu_data_packed_1,
  output logic [7:0]           mpu_data_packed_2,
  output logic [7:0]           mpu_data_packed_3,
  output logic [7:0]           mpu_data_packed_4,
  output logic [7:0]           mpu_data_packed_5,
  output logic [7:0]           mpu_data_packed_6,
  output logic [7:0]           mpu_data_packed_7,
  output logic [7:0]           mpu_data_packed_8,
  output logic [7:0]           mpu_data_packed_9,
  output logic [7:0]           mpu_data_packed_10,
  output logic [7:0]           mpu_data_packed_11,
  output logic [7:0]           mpu_data_packed_12,
  output logic [7:0]           mpu_data_packed_13,
  output logic                 data_valid,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  if (SAMPLE_DIV < 64 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mpu_burst_reader: SAMPLE_DIV must be >= 64 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [1:0] OP_START     = 2'd0;
  localparam logic [1:0] OP_WRITE     = 2'd1;
  localparam logic [1:0] OP_READ_ACK  = 2'd2;
  localparam logic [1:0] OP_READ_NACK = 2'd3;

  localparam int            TW        = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_W, S_REG, S_ADDR_R, S_READ, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          outstanding;   // command accepted, response not yet seen
  logic [3:0]    idx;
  logic [7:0]    shadow   [14];
  logic [7:0]    data_out [14];

`ifdef MPU_READER_TIMEOUT_EN
  localparam int            WW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wdog;
`endif

  // Free-running sample divider; held at 0 while disabled so a tick can never
  // coincide with enable falling.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst || !enable) tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = enable && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.cmd_valid <= 1'b0;
      bus.cmd_op    <= OP_START;
      bus.cmd_data  <= 8'h00;
      outstanding   <= 1'b0;
      idx           <= 4'd0;
      data_valid    <= 1'b0;
      busy          <= 1'b0;
      err_cnt       <= 8'h00;
      // NOTE: the byte arrays are reset explicitly because they are a handful
      // of flops that must read 0 after reset; a real RAM would not be.
      for (int i = 0; i < 14; i++) begin
        shadow[i]   <= 8'h00;
        data_out[i] <= 8'h00;
      end
`ifdef MPU_READER_TIMEOUT_EN
      wdog <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // Ticks arriving outside IDLE are dropped, not queued.
          if (tick) begin
            state         <= S_ADDR_W;
            busy          <= 1'b1;
            bus.cmd_valid <= 1'b1;
            bus.cmd_op    <= OP_START;
            bus.cmd_data  <= {DEV_ADDR, 1'b0};
          end
`ifdef MPU_READER_TIMEOUT_EN
          wdog <= '0;
`endif
        end

        S_ADDR_W, S_REG, S_ADDR_R, S_READ: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            outstanding   <= 1'b1;
`ifdef MPU_READER_TIMEOUT_EN
            wdog <= '0;
`endif
          end else if (outstanding && bus.rsp_valid) begin
            outstanding <= 1'b0;
`ifdef MPU_READER_TIMEOUT_EN
            wdog <= '0;
`endif
            if (bus.rsp_nack && state != S_READ) begin
              state <= S_ERR;
            end else begin
              case (state)
                S_ADDR_W: begin
                  state         <= S_REG;
                  bus.cmd_valid <= 1'b1;
                  bus.cmd_op    <= OP_WRITE;
                  bus.cmd_data  <= START_REG;
                end
                S_REG: begin
                  state         <= S_ADDR_R;
                  bus.cmd_valid <= 1'b1;
                  bus.cmd_op    <= OP_START;
                  bus.cmd_data  <= {DEV_ADDR, 1'b1};
                end
                S_ADDR_R: begin
                  state         <= S_READ;
                  idx           <= 4'd0;
                  bus.cmd_valid <= 1'b1;
                  bus.cmd_op    <= OP_READ_ACK;
                  bus.cmd_data  <= 8'h00;
                end
                default: begin  // S_READ
                  shadow[idx] <= bus.rsp_data;
                  if (idx == 4'd13) begin
                    // Publish on the final response edge so the registered
                    // data_valid is high exactly during DONE.
                    for (int i = 0; i < 13; i++) data_out[i] <= shadow[i];
                    data_out[13] <= bus.rsp_data;
                    data_valid   <= 1'b1;
                    state        <= S_DONE;
                  end else begin
                    idx           <= idx + 4'd1;
                    bus.cmd_valid <= 1'b1;
                    bus.cmd_op    <= (idx == 4'd12) ? OP_READ_NACK : OP_READ_ACK;
                    bus.cmd_data  <= 8'h00;
                  end
                end
              endcase
            end
          end
`ifdef MPU_READER_TIMEOUT_EN
          else if (wdog == WDOG_LAST) begin
            state         <= S_ERR;
            bus.cmd_valid <= 1'b0;
            outstanding   <= 1'b0;
            wdog          <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        S_ERR: begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign mpu_data_packed_0  = data_out[0];
  assign mpu_data_packed_1  = data_out[1];
  assign mpu_data_packed_2  = data_out[2];
  assign mpu_data_packed_3  = data_out[3];
  assign mpu_data_packed_4  = data_out[4];
  assign mpu_data_packed_5  = data_out[5];
  assign mpu_data_packed_6  = data_out[6];
  assign mpu_data_packed_7  = data_out[7];
  assign mpu_data_packed_8  = data_out[8];
  assign mpu_data_packed_9  = data_out[9];
  assign mpu_data_packed_10 = data_out[10];
  assign mpu_data_packed_11 = data_out[11];
  assign mpu_data_packed_12 = data_out[12];
  assign mpu_data_packed_13 = data_out[13];

endmodule

// File: tb/tb_mpu_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_mpu_burst_reader
//   Directed bench for mpu_burst_reader with a behavioural I2C-master model
//   that returns bytes 0x00..0x0D for every burst. Covers reset, nominal
//   bursts and their period, backpressure stability, NACK on the address
//   write, enable dropping mid-burst and a missing response.
// ---------------------------------------------------------------------------
module tb_mpu_burst_reader;
  localparam int SAMPLE_DIV     = 64;
  localparam int TIMEOUT_CYCLES = 100;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  always #5 clk = ~clk;

  mpu_burst_reader_if bus();
  wire [7:0] pk [14];
  logic      data_valid;
  logic      busy;
  logic [7:0] err_cnt;

  mpu_burst_reader #(
    .SAMPLE_DIV     (SAMPLE_DIV),
    .DEV_ADDR       (7'h68),
    .START_REG      (8'h3B),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .bus                (bus.master),
    .mpu_data_packed_0  (pk[0]),
    .mpu_data_packed_1  (pk[1]),
    .mpu_data_packed_2  (pk[2]),
    .mpu_data_packed_3  (pk[3]),
    .mpu_data_packed_4  (pk[4]),
    .mpu_data_packed_5  (pk[5]),
    .mpu_data_packed_6  (pk[6]),
    .mpu_data_packed_7  (pk[7]),
    .mpu_data_packed_8  (pk[8]),
    .mpu_data_packed_9  (pk[9]),
    .mpu_data_packed_10 (pk[10]),
    .mpu_data_packed_11 (pk[11]),
    .mpu_data_packed_12 (pk[12]),
    .mpu_data_packed_13 (pk[13]),
    .data_valid         (data_valid),
    .busy               (busy),
    .err_cnt            (err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Cycle counter and monitors
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   starts[$];
  int   dv_count = 0;
  int   dv_cyc   = 0;
  logic busy_q   = 1'b0;
  logic dv_prev  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && busy_q === 1'b0) starts.push_back(cyc);
      busy_q = busy;
      if (data_valid === 1'b1) begin
        check("dv_single_cycle", {31'd0, dv_prev}, 32'd0);
        dv_count++;
        dv_cyc = cyc;
      end
      dv_prev = data_valid;
    end
  end

  // I2C master model
  int         stall     = 0;
  logic       nack_once = 1'b0;
  logic       drop_reg  = 1'b0;
  logic [7:0] rd_byte   = 8'h00;
  int         rsp3_cyc  = 0;
  logic [9:0] cmd_log[$];

  initial begin
    logic [1:0] op;
    logic [7:0] d;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 8'h00;
    bus.rsp_nack  = 1'b0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      bus.rsp_nack  = 1'b0;
      bus.rsp_data  = 8'h00;
      bus.cmd_ready = 1'b0;
      if (rst !== 1'b0 || bus.cmd_valid !== 1'b1) continue;
      op = bus.cmd_op;
      d  = bus.cmd_data;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("cmd_stable", {21'd0, bus.cmd_valid, bus.cmd_op, bus.cmd_data}, {21'd0, 1'b1, op, d});
      end
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      cmd_log.push_back({op, d});
      if (op == 2'd0 && d == 8'hD0) rd_byte = 8'h00;
      if (drop_reg && op == 2'd1) continue;
      bus.rsp_valid = 1'b1;
      if (op >= 2'd2) begin
        bus.rsp_data = rd_byte;
        rd_byte      = rd_byte + 8'd1;
      end
      if (op == 2'd0 && d == 8'hD0 && nack_once) begin
        bus.rsp_nack = 1'b1;
        nack_once    = 1'b0;
      end
      if (op == 2'd3) rsp3_cyc = cyc;
    end
  end

  // Helpers
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dv(input int target, input int budget, input string tag);
    int n = 0;
    while (dv_count < target && n < budget) begin step(); n++; end
    check({tag, "_dv_wait"}, {31'd0, dv_count >= target}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin step(); n++; end
    check({tag, "_idle_wait"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_log(input int target, input int budget, input string tag);
    int n = 0;
    while (cmd_log.size() < target && n < budget) begin step(); n++; end
    check({tag, "_log_wait"}, {31'd0, cmd_log.size() >= target}, 32'd1);
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int n = 0;
    while (starts.size() < target && n < budget) begin step(); n++; end
    check({tag, "_start_wait"}, {31'd0, starts.size() >= target}, 32'd1);
  endtask

  task automatic check_bytes(input string tag);
    for (int k = 0; k < 14; k++)
      check($sformatf("%s_byte%0d", tag, k), {24'd0, pk[k]}, k);
  endtask

  task automatic check_log(input string tag);
    logic [9:0] exp;
    check({tag, "_log_len"}, cmd_log.size(), 32'd17);
    if (cmd_log.size() == 17) begin
      for (int j = 0; j < 17; j++) begin
        if (j == 0)       exp = {2'd0, 8'hD0};
        else if (j == 1)  exp = {2'd1, 8'h3B};
        else if (j == 2)  exp = {2'd0, 8'hD1};
        else if (j == 16) exp = {2'd3, 8'h00};
        else              exp = {2'd2, 8'h00};
        check($sformatf("%s_cmd%0d", tag, j), {22'd0, cmd_log[j]}, {22'd0, exp});
      end
    end
  endtask

  initial begin
    int n0;
    int ns;
    int n;
    rst    = 1'b1;
    enable = 1'b0;

    // 1: reset
    repeat (2) @(posedge clk);
    step();
    check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check("rst_cmd_op", {30'd0, bus.cmd_op}, 32'd0);
    check("rst_cmd_data", {24'd0, bus.cmd_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    for (int k = 0; k < 14; k++) check($sformatf("rst_byte%0d", k), {24'd0, pk[k]}, 32'd0);
    rst    = 1'b0;
    enable = 1'b1;

    // 2: nominal bursts
    wait_dv(1, 300, "nom");
    check_log("nom");
    check_bytes("nom");
    check("nom_latency", dv_cyc, rsp3_cyc + 1);
    check("nom_err_cnt", {24'd0, err_cnt}, 32'd0);
    step();
    check("nom_dv_low", {31'd0, data_valid}, 32'd0);
    check("nom_busy_low", {31'd0, busy}, 32'd0);
    cmd_log.delete();
    wait_starts(2, 200, "nom2");
    if (starts.size() >= 2) check("nom_period", starts[1] - starts[0], 32'd64);
    wait_dv(2, 200, "nom2");
    check_log("nom2");
    check_bytes("nom2");

    // 3: backpressure
    enable = 1'b0;
    wait_idle(200, "bp");
    stall = 10;
    cmd_log.delete();
    n0 = dv_count;
    enable = 1'b1;
    wait_dv(n0 + 1, 800, "bp");
    check_log("bp");
    check_bytes("bp");

    // 4: NACK on ADDR_W, retry at the next tick
    enable = 1'b0;
    wait_idle(400, "nack");
    stall     = 0;
    nack_once = 1'b1;
    n0 = dv_count;
    ns = starts.size();
    enable = 1'b1;
    n = 0;
    while (err_cnt !== 8'd1 && n < 300) begin step(); n++; end
    check("nack_err_cnt", {24'd0, err_cnt}, 32'd1);
    check("nack_no_dv", dv_count, n0);
    check("nack_busy", {31'd0, busy}, 32'd0);
    check_bytes("nack_hold");
    wait_dv(n0 + 1, 300, "retry");
    if (starts.size() >= ns + 2) check("retry_period", starts[ns + 1] - starts[ns], 32'd64);
    else check("retry_starts", starts.size(), ns + 2);
    check("retry_err_cnt", {24'd0, err_cnt}, 32'd1);
    check_bytes("retry");

    // 5: enable drops at READ idx 5
    enable = 1'b0;
    wait_idle(200, "en");
    cmd_log.delete();
    n0 = dv_count;
    enable = 1'b1;
    wait_log(8, 300, "en");
    enable = 1'b0;
    wait_dv(n0 + 1, 200, "en");
    check("en_log_len", cmd_log.size(), 32'd17);
    check_bytes("en");
    ns = starts.size();
    repeat (200) step();
    check("en_quiet_log", cmd_log.size(), 32'd17);
    check("en_quiet_starts", starts.size(), ns);
    check("en_quiet_busy", {31'd0, busy}, 32'd0);

    // 6: no response after REG
    cmd_log.delete();
    drop_reg = 1'b1;
    enable   = 1'b1;
    wait_log(2, 300, "hang");
`ifdef MPU_READER_TIMEOUT_EN
    n = 0;
    while (err_cnt !== 8'd2 && n < 400) begin step(); n++; end
    check("wdog_err_cnt", {24'd0, err_cnt}, 32'd2);
    check("wdog_latency", {31'd0, (n >= 95 && n <= 105)}, 32'd1);
`else
    repeat (300) step();
    check("hang_busy", {31'd0, busy}, 32'd1);
    check("hang_err_cnt", {24'd0, err_cnt}, 32'd1);
    check("hang_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
